uart_status_framer: RTL and testbench

//   Telemetry path back to the host: serialises per-motor 32-bit status words into UART frames.

---
 rtl/uart_status_framer_if.sv | 10 +
 rtl/uart_status_framer.sv | 184 ++++++++++++++++++
 tb/tb_uart_status_framer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_status_framer_if.sv
// Byte-level handshake between the status framer and the async UART transmitter.
// The framer is the master: it offers a byte with tx_start, the transmitter answers with tx_busy.
interface uart_status_framer_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/uart_status_framer.sv
// Serialises the 32-bit status words of the enabled motors into 7-byte UART frames:
// SYNC, index, data LSB first, XOR checksum of index and data bytes.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IDLE      | waiting for send_req or a pending request
//   SCAN      | walking the latched mask, skipping disabled motors
//   LOAD      | snapshot the motor word, frame starts with SYNC
//   START     | offer current byte once the transmitter is idle
//   WAIT_ACK  | waiting for tx_busy to rise, bounded by ACK_TIMEOUT
//   WAIT_DONE | waiting for tx_busy to fall, then advance the byte
//   DONE      | one-cycle sweep_done, back to IDLE
module uart_status_framer #(
    parameter int          NUM_MOTORS  = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'h53,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic                     CLK_SE_AR,
    input  logic                     reset,
    input  logic                     send_req,
    input  logic [NUM_MOTORS-1:0]    motor_mask,
    input  logic [NUM_MOTORS*32-1:0] status_flat,
    uart_status_framer_if.master     tx,
    output logic                     active,
    output logic                     sweep_done,
    output logic                     tx_error
);

    localparam int IDX_W  = $clog2(NUM_MOTORS + 1);
    localparam int MASK_W = 1 << IDX_W;
    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SCAN      = 3'd1;
    localparam logic [2:0] LOAD      = 3'd2;
    localparam logic [2:0] START     = 3'd3;
    localparam logic [2:0] WAIT_ACK  = 3'd4;
    localparam logic [2:0] WAIT_DONE = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]        state_q,    state_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [MASK_W-1:0] mask_q,     mask_d;
    logic [31:0]       data_q,     data_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        chk_q,      chk_d;
    logic [7:0]        tx_data_q,  tx_data_d;
    logic [TMO_W-1:0]  tmo_q,      tmo_d;
    logic              pending_q,  pending_d;
    logic              tx_error_q, tx_error_d;
    logic [31:0]       word_sel;

    function automatic logic [7:0] frame_byte(input logic [2:0]       n,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [31:0]      d,
                                              input logic [7:0]       chk);
        case (n)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = 8'(idx);
            3'd2:    frame_byte = d[7:0];
            3'd3:    frame_byte = d[15:8];
            3'd4:    frame_byte = d[23:16];
            3'd5:    frame_byte = d[31:24];
            default: frame_byte = chk;
        endcase
    endfunction

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (idx_q == IDX_W'(i)) word_sel = status_flat[32*i +: 32];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        data_d     = data_q;
        byte_cnt_d = byte_cnt_q;
        chk_d      = chk_q;
        tx_data_d  = tx_data_q;
        tmo_d      = tmo_q;
        tx_error_d = tx_error_q;
        // A request arriving mid-sweep merges into a single pending sweep.
        pending_d  = pending_q | (send_req && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (send_req || pending_q) begin
                    mask_d    = MASK_W'(motor_mask);
                    idx_d     = '0;
                    pending_d = 1'b0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (idx_q == IDX_W'(NUM_MOTORS)) begin
                    state_d = DONE;
                end else if (!mask_q[idx_q]) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d     = word_sel;
                byte_cnt_d = '0;
                chk_d      = '0;
                tx_data_d  = SYNC_BYTE;
                state_d    = START;
            end
            START: begin
                if (!tx.tx_busy) begin
                    tmo_d   = TMO_W'(ACK_TIMEOUT - 1);
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == '0) begin
                    tx_error_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx.tx_busy) begin
                    if (byte_cnt_q >= 3'd1 && byte_cnt_q <= 3'd5) chk_d = chk_q ^ tx_data_q;
                    if (byte_cnt_q == 3'd6) begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SCAN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        tx_data_d  = frame_byte(byte_cnt_q + 3'd1, idx_q, data_q, chk_d);
                        state_d    = START;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_SE_AR) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            chk_q      <= '0;
            tx_data_q  <= '0;
            tmo_q      <= '0;
            pending_q  <= 1'b0;
            tx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            byte_cnt_q <= byte_cnt_d;
            chk_q      <= chk_d;
            tx_data_q  <= tx_data_d;
            tmo_q      <= tmo_d;
            pending_q  <= pending_d;
            tx_error_q <= tx_error_d;
        end
    end

    // tx_start is gated by tx_busy so it can never coincide with a busy transmitter.
    assign tx.tx_start = (state_q == START) && !tx.tx_busy;
    assign tx.tx_data  = tx_data_q;
    assign active      = (state_q != IDLE);
    assign sweep_done  = (state_q == DONE);
    assign tx_error    = tx_error_q;

endmodule

// File: tb/tb_uart_status_framer.sv
// Scoreboard bench for uart_status_framer: expected frames are queued when a sweep is requested,
// a monitor pops them as tx_start bytes appear; a BFM plays the UART transmitter.
module tb_uart_status_framer;
    localparam int         N      = 10;
    localparam int         ACK_TO = 15;
    localparam logic [7:0] SYNC   = 8'h53;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             send_req = 1'b0;
    logic [N-1:0]     motor_mask = '0;
    logic [N*32-1:0]  status_flat = '0;
    logic             active, sweep_done, tx_error;

    uart_status_framer_if u_if();

    uart_status_framer #(.NUM_MOTORS(N), .SYNC_BYTE(SYNC), .ACK_TIMEOUT(ACK_TO)) dut (
        .CLK_SE_AR   (clk),
        .reset       (reset),
        .send_req    (send_req),
        .motor_mask  (motor_mask),
        .status_flat (status_flat),
        .tx          (u_if),
        .active      (active),
        .sweep_done  (sweep_done),
        .tx_error    (tx_error)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic [31:0] words [N];
    int         done_cnt = 0, start_cnt = 0, viol = 0;
    int         first_start_cyc = -1, done_cyc = -1, err_cyc = -1, req_cyc = 0;
    bit         prev_start = 1'b0;
    bit         dead = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy rises the cycle after tx_start and stays up a random while.
    initial begin
        u_if.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (u_if.tx_start && !dead && !reset) begin
                @(posedge clk);
                #1 u_if.tx_busy = 1'b1;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1 u_if.tx_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (u_if.tx_start) begin
                start_cnt++;
                if (first_start_cyc < 0) first_start_cyc = cyc;
                if (u_if.tx_busy || prev_start) viol++;
                log_q.push_back(u_if.tx_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h expected none", u_if.tx_data);
                end else begin
                    check("tx_byte", int'(u_if.tx_data), int'(exp_q.pop_front()));
                end
            end
            prev_start = u_if.tx_start;
            if (sweep_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (tx_error && err_cyc < 0) err_cyc = cyc;
        end
    end

    task automatic apply_status();
        for (int i = 0; i < N; i++) status_flat[32*i +: 32] = words[i];
    endtask

    // Reference: one frame per enabled motor, in index order, checksum over bytes 1..5.
    task automatic push_frames(input logic [N-1:0] m);
        logic [7:0] b [7];
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                b[0] = SYNC;
                b[1] = 8'(i);
                for (int k = 0; k < 4; k++) b[2+k] = words[i][8*k +: 8];
                b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
                for (int k = 0; k < 7; k++) exp_q.push_back(b[k]);
            end
        end
    endtask

    task automatic send_pulse();
        @(posedge clk);
        #1 send_req = 1'b1;
        req_cyc = cyc;
        @(posedge clk);
        #1 send_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("sweep_done_count", done_cnt, target);
    endtask

    task automatic run_sweep(input logic [N-1:0] m);
        int tgt;
        tgt = done_cnt + 1;
        motor_mask = m;
        push_frames(m);
        send_pulse();
        wait_done(tgt, 3000);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_log(input int n_bytes);
        int n = 0;
        while (log_q.size() < n_bytes && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("bytes_seen", (log_q.size() >= n_bytes) ? 1 : 0, 1);
    endtask

    initial begin
        logic [7:0] t1 [7];
        logic [7:0] t2 [14];
        int tgt;

        t1 = '{8'h53, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        t2 = '{8'h53, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h03,
               8'h53, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09};
        for (int i = 0; i < N; i++) words[i] = '0;
        apply_status();

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_active", active, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_tx_error", tx_error, 0);
        check("rst_tx_start", u_if.tx_start, 0);
        check("rst_tx_data", u_if.tx_data, 0);

        // Single motor frame and request-to-first-byte latency.
        words[0] = 32'h12345678;
        apply_status();
        log_q.delete();
        first_start_cyc = -1;
        run_sweep(10'h001);
        check("latency_first_start", first_start_cyc - req_cyc, 3);
        check("t1_len", log_q.size(), 7);
        for (int i = 0; i < 7; i++) check("t1_byte", (i < log_q.size()) ? int'(log_q[i]) : -1, int'(t1[i]));

        // Two frames in index order.
        words[2] = 32'hFFFF0001;
        words[9] = 32'h0;
        apply_status();
        log_q.delete();
        run_sweep(10'h204);
        check("t2_len", log_q.size(), 14);
        for (int i = 0; i < 14; i++) check("t2_byte", (i < log_q.size()) ? int'(log_q[i]) : -1, int'(t2[i]));

        // Requests during a sweep merge into exactly one follow-up sweep.
        log_q.delete();
        tgt = done_cnt + 2;
        motor_mask = 10'h204;
        push_frames(10'h204);
        push_frames(10'h204);
        send_pulse();
        repeat (5) @(posedge clk);
        check("active_at_req2", active, 1);
        send_pulse();
        repeat (10) @(posedge clk);
        check("active_at_req3", active, 1);
        send_pulse();
        wait_done(tgt, 6000);
        repeat (40) @(posedge clk);
        check("pending_no_third_sweep", done_cnt, tgt);
        check("pending_len", log_q.size(), 28);

        // Empty mask: no bytes, sweep_done after NUM_MOTORS+2 cycles.
        log_q.delete();
        run_sweep('0);
        check("empty_latency", done_cyc - req_cyc, N + 2);
        check("empty_len", log_q.size(), 0);

        // Word changes mid-frame; the snapshot must survive.
        words[0] = 32'hAAAAAAAA;
        apply_status();
        log_q.delete();
        tgt = done_cnt + 1;
        motor_mask = 10'h001;
        push_frames(10'h001);
        send_pulse();
        wait_log(4);
        #1 status_flat[31:0] = 32'h55555555;
        wait_done(tgt, 3000);
        check("snap_len", log_q.size(), 7);
        for (int i = 2; i < 6; i++) check("snap_data", (i < log_q.size()) ? int'(log_q[i]) : -1, 8'hAA);
        check("snap_chk", (log_q.size() == 7) ? int'(log_q[6]) : -1, 8'h00);
        words[0] = 32'h55555555;

        // Randomized sweeps.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++) words[i] = $urandom;
            apply_status();
            run_sweep(N'($urandom_range(0, (1 << N) - 1)));
        end

        // Dead transmitter: abort with sticky tx_error.
        dead = 1'b1;
        log_q.delete();
        words[0] = $urandom;
        apply_status();
        first_start_cyc = -1;
        err_cyc = -1;
        tgt = done_cnt + 1;
        motor_mask = 10'h001;
        exp_q.push_back(SYNC);
        send_pulse();
        wait_done(tgt, 300);
        check("timeout_cycles", err_cyc - first_start_cyc, ACK_TO + 1);
        check("timeout_done_cycle", done_cyc - first_start_cyc, ACK_TO + 1);
        repeat (40) @(posedge clk);
        check("timeout_one_start", log_q.size(), 1);
        check("tx_error_sticky", tx_error, 1);
        check("timeout_idle", active, 0);

        // Reset in the middle of byte 4, then a clean frame.
        dead = 1'b0;
        log_q.delete();
        words[3] = $urandom;
        apply_status();
        motor_mask = 10'h008;
        push_frames(10'h008);
        send_pulse();
        wait_log(5);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_active", active, 0);
        check("midrst_tx_start", u_if.tx_start, 0);
        check("midrst_tx_error", tx_error, 0);
        log_q.delete();
        repeat (30) @(posedge clk);
        check("midrst_silent", log_q.size(), 0);
        run_sweep(10'h008);
        check("post_rst_len", log_q.size(), 7);
        check("post_rst_sync", (log_q.size() > 0) ? int'(log_q[0]) : -1, SYNC);

        check("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
